seq_mul_ctrl: RTL and testbench

Handshake front-end for the 4-bit shift-add sequential multiplier (`seq_mul`).
- Upstream: accepts operand pairs over a valid/ready interface.
- Multiplier side: registers the operands, issues the single-cycle `start` pulse and drives `a`/`b`, then counts a fixed multiplier latency.
- Downstream: captures `op` and presents it over a valid/ready interface.
- It is the only agent that drives the multiplier, so the multiplier stays free of handshake logic.

---
 rtl/seq_mul_pkg.sv | 19 +
 rtl/seq_mul_ctrl_lat_cnt.sv | 49 ++++
 rtl/seq_mul_ctrl.sv | 171 +++++++++++++++++
 tb/tb_seq_mul_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_pkg
// Shared definitions for the sequential-multiplier front-end: the controller
// state encoding, operand/product widths and the default multiplier latency.
// -----------------------------------------------------------------------------
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int OPW             = 4;   // operand width
    localparam int PW              = 8;   // full product width, 4x4 -> 8
    localparam int MUL_LAT_DEFAULT = 6;   // seq_mul latency in rising edges

endpackage

// File: rtl/seq_mul_ctrl_lat_cnt.sv
// -----------------------------------------------------------------------------
// lat_cnt
// Loadable down-counter used to time the multiplier latency.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset, clears the count
//   load_i     in   load load_val_i this cycle (has priority over dec_i)
//   load_val_i in   W  value to load
//   dec_i      in   decrement by one, saturating at zero
//   cnt_o      out  W  current count
//   zero_o     out  count is zero
// -----------------------------------------------------------------------------
module lat_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_mul_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mul_ctrl
// Handshake front-end for the 4-bit shift-add sequential multiplier seq_mul.
// Accepts operand pairs over valid/ready, registers them onto mul_a/mul_b,
// issues a one-cycle mul_start, waits MUL_LAT edges, captures mul_op and
// presents the result over valid/ready. A new pair can be accepted in the
// same cycle the previous result is taken, so there is no idle bubble.
//
// Optional feature macro: SEQ_MUL_CTRL_ACC_EN
//   defined   -> ACC_W-bit running sum of products on out_data; in_first
//                restarts the sum with the current product.
//   undefined -> out_data is the 8-bit product; in_first and ACC_W unused.
//
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   in_valid, in_ready    upstream handshake
//   in_a, in_b            operands (4 bit each)
//   in_first              restart accumulation (accumulator builds only)
//   mul_start             single-cycle start pulse to seq_mul
//   mul_a, mul_b          registered operands to seq_mul
//   mul_op                product from seq_mul
//   out_valid, out_ready  downstream handshake
//   out_data              product (8 bit) or running sum (ACC_W bit)
//   busy                  controller not in IDLE
// -----------------------------------------------------------------------------
module seq_mul_ctrl
    import seq_mul_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_a,
    input  logic [OPW-1:0]   in_b,
    input  logic             in_first,
    output logic             mul_start,
    output logic [OPW-1:0]   mul_a,
    output logic [OPW-1:0]   mul_b,
    input  logic [PW-1:0]    mul_op,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SEQ_MUL_CTRL_ACC_EN
    output logic [ACC_W-1:0] out_data,
`else
    output logic [PW-1:0]    out_data,
`endif
    output logic             busy
);

    // Counter holds values up to MUL_LAT-1.
    localparam int            CW       = $clog2(MUL_LAT);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MUL_LAT - 1);

    state_e           state_q;
    logic [OPW-1:0]   mul_a_q;
    logic [OPW-1:0]   mul_b_q;
    logic             mul_start_q;
    logic             out_valid_q;
    logic             cnt_zero;
    logic [CW-1:0]    cnt_val;

`ifdef SEQ_MUL_CTRL_ACC_EN
    logic             first_q;
    logic [ACC_W-1:0] acc_q;
`else
    logic [PW-1:0]    res_q;
    logic             unused_first;
    logic [ACC_W-1:0] unused_acc_w;
    assign unused_first = in_first;
    assign unused_acc_w = '0;
`endif

    logic             unused_cnt;
    assign unused_cnt = ^cnt_val;

    // In DONE the upstream handshake passes through the downstream one so
    // a result hand-off and a new acceptance can share one edge.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

    lat_cnt #(
        .W (CW)
    ) u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == START),
        .load_val_i (LOAD_VAL),
        .dec_i      (state_q == WAIT),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SEQ_MUL_CTRL_ACC_EN
            first_q     <= 1'b0;
            acc_q       <= '0;
`else
            res_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mul_a_q     <= in_a;
                        mul_b_q     <= in_b;
`ifdef SEQ_MUL_CTRL_ACC_EN
                        first_q     <= in_first;
`endif
                        mul_start_q <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    mul_start_q <= 1'b0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (cnt_zero) begin
`ifdef SEQ_MUL_CTRL_ACC_EN
                        acc_q <= first_q ? ACC_W'(mul_op)
                                         : acc_q + ACC_W'(mul_op);
`else
                        res_q <= mul_op;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            mul_a_q     <= in_a;
                            mul_b_q     <= in_b;
`ifdef SEQ_MUL_CTRL_ACC_EN
                            first_q     <= in_first;
`endif
                            mul_start_q <= 1'b1;
                            state_q     <= START;
                        end else begin
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
`ifdef SEQ_MUL_CTRL_ACC_EN
    assign out_data  = acc_q;
`else
    assign out_data  = res_q;
`endif

endmodule

// File: tb/tb_seq_mul_ctrl.sv
module tb_seq_mul_ctrl;
    import seq_mul_pkg::*;

    parameter int LAT = MUL_LAT_DEFAULT;
    localparam int ACC_W = 12;
`ifdef SEQ_MUL_CTRL_ACC_EN
    localparam int OW = ACC_W;
`else
    localparam int OW = PW;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     in_a = '0;
    logic [3:0]     in_b = '0;
    logic           in_first = 1'b0;
    logic           mul_start;
    logic [3:0]     mul_a;
    logic [3:0]     mul_b;
    logic [7:0]     mul_op;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [OW-1:0]  out_data;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] acc_m = '0;

    seq_mul_ctrl #(
        .MUL_LAT (LAT),
        .ACC_W   (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_op    (mul_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural seq_mul: product becomes final exactly LAT edges after the
    // edge sampling start; before that mul_op shows a wrong (inverted) value.
    logic [7:0] m_prod = '0;
    logic [7:0] m_op   = '0;
    int         m_cnt  = 0;
    always @(posedge clk) begin
        if (mul_start) begin
            m_prod <= {4'b0, mul_a} * {4'b0, mul_b};
            m_op   <= ~({4'b0, mul_a} * {4'b0, mul_b});
            m_cnt  <= LAT - 1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_op <= m_prod;
        end
    end
    assign mul_op = m_op;

    // Start-pulse monitor (values sampled before the edge updates).
    int   start_edges = 0;
    int   start_dbl   = 0;
    int   start_rdy   = 0;
    logic start_prev  = 1'b0;
    always @(posedge clk) begin
        if (mul_start) start_edges++;
        if (mul_start && start_prev) start_dbl++;
        if (mul_start && in_ready) start_rdy++;
        start_prev = mul_start;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [3:0] b, input logic first);
        logic [7:0] p;
        p = {4'b0, a} * {4'b0, b};
`ifdef SEQ_MUL_CTRL_ACC_EN
        acc_m = first ? OW'(p) : acc_m + OW'(p);
        exp_q.push_back(acc_m);
`else
        exp_q.push_back(p);
`endif
    endtask

    // Sends one pair, waits for out_valid. Does not complete the output transfer.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic first,
                         output logic [OW-1:0] got, output int lat, output bit to);
        int acc_cyc;
        to = 1'b0; lat = -1; got = '0;
        in_a = a; in_b = b; in_first = first; in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (in_ready) break;
            step();
        end
        if (!in_ready) begin
            to = 1'b1;
            in_valid = 1'b0;
            return;
        end
        step();
        acc_cyc = cyc;
        push_exp(a, b, first);
        in_valid = 1'b0;
        for (int i = 0; i < LAT + 20; i++) begin
            if (out_valid) break;
            step();
        end
        if (!out_valid) begin
            to = 1'b1;
        end else begin
            got = out_data;
            lat = cyc - acc_cyc;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) step();
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_tests++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL reset_mul_start got=%b want=0", mul_start); end
        n_tests++; if (mul_a !== 4'd0)     begin n_fail++; $display("FAIL reset_mul_a got=%0d want=0", mul_a); end
        n_tests++; if (mul_b !== 4'd0)     begin n_fail++; $display("FAIL reset_mul_b got=%0d want=0", mul_b); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_tests++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        acc_m = '0;
        step();
    endtask

    task automatic test_basic();
        logic [OW-1:0] got, exp;
        int lat, s0;
        bit to;
        out_ready = 1'b1;
        s0 = start_edges;
        do_op(4'd3, 4'd5, 1'b0, got, lat, to);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_tests++; if (to)               begin n_fail++; $display("FAIL basic_timeout got=timeout want=out_valid"); end
        n_tests++; if (got !== exp)      begin n_fail++; $display("FAIL basic_data got=%0d want=%0d", got, exp); end
        n_tests++; if (lat != LAT + 1)   begin n_fail++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT + 1); end
        n_tests++; if (start_edges - s0 != 1) begin n_fail++; $display("FAIL basic_start_pulses got=%0d want=1", start_edges - s0); end
        step();
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid got=%b want=0", out_valid); end
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL basic_idle_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_stall();
        logic [OW-1:0] got, exp;
        int lat;
        bit to;
        out_ready = 1'b0;
        do_op(4'd15, 4'd15, 1'b0, got, lat, to);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_tests++; if (to) begin n_fail++; $display("FAIL stall_timeout got=timeout want=out_valid"); end
        // Offer a new pair during the stall; it must not be taken.
        in_a = 4'd1; in_b = 4'd2; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_tests++; if (out_data !== exp)   begin n_fail++; $display("FAIL stall_data[%0d] got=%0d want=%0d", i, out_data, exp); end
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got=%b want=1", i, out_valid); end
            n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL stall_in_ready[%0d] got=%b want=0", i, in_ready); end
            n_tests++; if (mul_a !== 4'd15)    begin n_fail++; $display("FAIL stall_mul_a[%0d] got=%0d want=15", i, mul_a); end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got=%b want=1", in_ready); end
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_done_valid got=%b want=0", out_valid); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL stall_done_busy got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        int n_acc, n_out;
        int acc_c[2];
        int out_c[2];
        bit acc2_in_done, will_acc, will_out;
        logic [OW-1:0] d, exp;
        n_acc = 0; n_out = 0; acc2_in_done = 1'b0;
        acc_c[0] = 0; acc_c[1] = 0; out_c[0] = 0; out_c[1] = 0;
        out_ready = 1'b1;
        in_a = 4'd2; in_b = 4'd7; in_first = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4 * (LAT + 2) + 10; i++) begin
            if (n_out >= 2) break;
            will_acc = in_valid && in_ready;
            will_out = out_valid && out_ready;
            d = out_data;
            if (will_acc && n_acc == 1) acc2_in_done = out_valid;
            step();
            if (will_out) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                n_tests++; if (d !== exp) begin n_fail++; $display("FAIL b2b_data[%0d] got=%0d want=%0d", n_out, d, exp); end
                out_c[n_out] = cyc;
                n_out++;
            end
            if (will_acc) begin
                push_exp(in_a, in_b, in_first);
                acc_c[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    in_a = 4'd9; in_b = 4'd4;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        n_tests++; if (n_out != 2)          begin n_fail++; $display("FAIL b2b_outputs got=%0d want=2", n_out); end
        n_tests++; if (acc2_in_done !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_in_done got=%b want=1", acc2_in_done); end
        n_tests++; if (acc_c[1] != out_c[0]) begin n_fail++; $display("FAIL b2b_accept_edge got=%0d want=%0d", acc_c[1], out_c[0]); end
        n_tests++; if (out_c[1] - out_c[0] != LAT + 2) begin n_fail++; $display("FAIL b2b_spacing got=%0d want=%0d", out_c[1] - out_c[0], LAT + 2); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [OW-1:0] got, exp;
        int lat;
        bit to, seen_valid;
        out_ready = 1'b1;
        // Reset while mul_start is high.
        in_a = 4'd6; in_b = 4'd6; in_valid = 1'b1;
        for (int i = 0; i < 64 && !in_ready; i++) step();
        step();
        in_valid = 1'b0;
        n_tests++; if (mul_start !== 1'b1) begin n_fail++; $display("FAIL rstmid_start_high got=%b want=1", mul_start); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_start_async got=%b want=0", mul_start); end
        step();
        rst_n = 1'b1;
        step();
        // Reset during WAIT.
        in_valid = 1'b1;
        for (int i = 0; i < 64 && !in_ready; i++) step();
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
        n_tests++; if (mul_a !== 4'd0)     begin n_fail++; $display("FAIL rstmid_mul_a got=%0d want=0", mul_a); end
        n_tests++; if (out_data !== '0)    begin n_fail++; $display("FAIL rstmid_out_data got=%0d want=0", out_data); end
        exp_q.delete();
        acc_m = '0;
        seen_valid = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 6; i++) begin
            if (out_valid) seen_valid = 1'b1;
            step();
        end
        n_tests++; if (seen_valid) begin n_fail++; $display("FAIL rstmid_no_valid got=1 want=0"); end
        do_op(4'd6, 4'd6, 1'b0, got, lat, to);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_tests++; if (to)          begin n_fail++; $display("FAIL rstmid_timeout got=timeout want=out_valid"); end
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rstmid_fresh got=%0d want=%0d", got, exp); end
        step();
    endtask

`ifdef SEQ_MUL_CTRL_ACC_EN
    task automatic test_acc();
        logic [OW-1:0] got, exp;
        int lat;
        bit to;
        logic [3:0] av[3];
        logic [3:0] bv[3];
        logic       fv[3];
        int         lit[3];
        av[0] = 4'd15; bv[0] = 4'd15; fv[0] = 1'b1; lit[0] = 225;
        av[1] = 4'd15; bv[1] = 4'd15; fv[1] = 1'b0; lit[1] = 450;
        av[2] = 4'd1;  bv[2] = 4'd1;  fv[2] = 1'b0; lit[2] = 451;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], fv[i], got, lat, to);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_tests++; if (to)                begin n_fail++; $display("FAIL acc_timeout[%0d] got=timeout want=out_valid", i); end
            n_tests++; if (got !== exp)       begin n_fail++; $display("FAIL acc_model[%0d] got=%0d want=%0d", i, got, exp); end
            n_tests++; if (got !== OW'(lit[i])) begin n_fail++; $display("FAIL acc_const[%0d] got=%0d want=%0d", i, got, lit[i]); end
            step();
        end
        for (int i = 0; i < 64; i++) begin
            do_op(4'd15, 4'd15, 1'b0, got, lat, to);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_tests++; if (to || got !== exp) begin n_fail++; $display("FAIL acc_wrap[%0d] got=%0d want=%0d", i, got, exp); end
            step();
        end
        n_tests++; if (got !== OW'(2563)) begin n_fail++; $display("FAIL acc_wrap_final got=%0d want=2563", got); end
    endtask
`endif

    task automatic test_start_rules();
        n_tests++; if (start_dbl != 0) begin n_fail++; $display("FAIL start_width got=%0d want=0", start_dbl); end
        n_tests++; if (start_rdy != 0) begin n_fail++; $display("FAIL start_with_ready got=%0d want=0", start_rdy); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef SEQ_MUL_CTRL_ACC_EN
        test_acc();
`endif
        test_start_rules();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
